// File: rtl/abc_pkt_arb.sv
// abc_pkt_arb: packet-atomic 8:1 arbiter for the ABC output channel.
// Picks one packet at a time: strict QoS first, round-robin inside each class,
// with a burst limit so a waiting low-QoS requester is not starved forever.
// Packets longer than MAX_PKT_LEN are cut (eop forced) and their tail drained.
//
// Handshake: a channel's head word is consumed on a rising edge where both
// ch_vld[i] and ch_pop[i] are 1; ch_pop is combinational from the current head
// and state. The output side has no backpressure: each cycle with data_vld=1
// carries exactly one word.
module abc_pkt_arb #(
  parameter int NCH          = 8,
  parameter int DW           = 8,
  parameter int MAX_HI_BURST = 4,
  parameter int MAX_PKT_LEN  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           ch_vld,
  input  logic [NCH*DW-1:0]        ch_data,
  input  logic [NCH-1:0]           ch_sop,
  input  logic [NCH-1:0]           ch_eop,
  input  logic [NCH-1:0]           ch_qos,
  output logic [NCH-1:0]           ch_pop,
  output logic [DW-1:0]            data_out,
  output logic                     sop_out,
  output logic                     eop_out,
  output logic                     qos_out,
  output logic [$clog2(NCH)-1:0]   id_out,
  output logic                     data_vld,
  output logic                     pkg_cnt_incr,
  output logic                     err_orphan,
  output logic                     err_trunc,
  output logic [NCH-1:0]           gnt,
  output logic [1:0]               state_dbg
);

  localparam int IDW = $clog2(NCH);
  localparam int PLW = $clog2(MAX_PKT_LEN + 1);
  localparam int HBW = $clog2(MAX_HI_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   hi_ptr;
  logic [IDW-1:0]   lo_ptr;
  logic [HBW-1:0]   hi_burst_cnt;
  logic [PLW-1:0]   pkt_len;
  logic [IDW-1:0]   cur_id;
  logic             cur_qos;

  logic [NCH-1:0]   req;
  logic [NCH-1:0]   orphan;
  logic [NCH-1:0]   hi_req;
  logic [NCH-1:0]   lo_req;
  logic             pick_hi;
  logic [NCH-1:0]   cls_req;
  logic [IDW-1:0]   cls_ptr;
  logic [IDW-1:0]   win_id;
  logic             win_found;
  logic [IDW-1:0]   nxt_ptr;
  logic [IDW:0]     rr_sum;
  logic [DW-1:0]    w_data;
  logic             w_eop;
  logic             w_vld;

  assign state_dbg = state;

  assign req     = ch_vld & ch_sop;
  assign orphan  = ch_vld & ~ch_sop;
  assign hi_req  = req & ch_qos;
  assign lo_req  = req & ~ch_qos;
  // High class wins unless low requesters have waited through a full burst.
  assign pick_hi = (|hi_req) && (!(|lo_req) || (hi_burst_cnt < HBW'(MAX_HI_BURST)));
  assign cls_req = pick_hi ? hi_req : lo_req;
  assign cls_ptr = pick_hi ? hi_ptr : lo_ptr;
  assign nxt_ptr = (win_id == IDW'(NCH - 1)) ? '0 : win_id + IDW'(1);
  assign w_vld   = |(gnt & ch_vld);

  // Round-robin search: first requester at or after the class pointer, wrapping.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    rr_sum    = '0;
    for (int k = 0; k < NCH; k++) begin
      rr_sum = {1'b0, cls_ptr} + (IDW+1)'(k);
      if (rr_sum >= (IDW+1)'(NCH)) rr_sum = rr_sum - (IDW+1)'(NCH);
      if (!win_found && cls_req[rr_sum[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = rr_sum[IDW-1:0];
      end
    end
  end

  // Head-word mux for the granted channel.
  always_comb begin
    w_data = '0;
    w_eop  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (cur_id == IDW'(i)) begin
        w_data = ch_data[i*DW +: DW];
        w_eop  = ch_eop[i];
      end
    end
  end

  // Pop strobes: flush orphans while idle, drain the winner otherwise; silent in reset.
  always_comb begin
    ch_pop = '0;
    if (rst_n) begin
      case (state)
        IDLE:        ch_pop = orphan;
        XFER, DRAIN: ch_pop = gnt & ch_vld;
        default:     ch_pop = '0;
      endcase
    end
  end

  // Arbitration FSM with registered output word, grant and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gnt          <= '0;
      hi_ptr       <= '0;
      lo_ptr       <= '0;
      hi_burst_cnt <= '0;
      pkt_len      <= '0;
      cur_id       <= '0;
      cur_qos      <= 1'b0;
      data_out     <= '0;
      sop_out      <= 1'b0;
      eop_out      <= 1'b0;
      qos_out      <= 1'b0;
      id_out       <= '0;
      data_vld     <= 1'b0;
      pkg_cnt_incr <= 1'b0;
      err_orphan   <= 1'b0;
      err_trunc    <= 1'b0;
    end else begin
      data_vld     <= 1'b0;
      sop_out      <= 1'b0;
      eop_out      <= 1'b0;
      pkg_cnt_incr <= 1'b0;
      err_orphan   <= 1'b0;
      err_trunc    <= 1'b0;
      case (state)
        IDLE: begin
          err_orphan <= |orphan;
          if (|req) begin
            gnt     <= {{(NCH-1){1'b0}}, 1'b1} << win_id;
            cur_id  <= win_id;
            cur_qos <= pick_hi;
            pkt_len <= '0;
            state   <= XFER;
            if (pick_hi) begin
              hi_ptr <= nxt_ptr;
              if (|lo_req) begin
                if (hi_burst_cnt != HBW'(MAX_HI_BURST))
                  hi_burst_cnt <= hi_burst_cnt + HBW'(1);
              end else begin
                hi_burst_cnt <= '0;
              end
            end else begin
              lo_ptr       <= nxt_ptr;
              hi_burst_cnt <= '0;
            end
          end
        end
        XFER: begin
          if (w_vld) begin
            data_out <= w_data;
            data_vld <= 1'b1;
            sop_out  <= (pkt_len == '0);
            id_out   <= cur_id;
            qos_out  <= cur_qos;
            if (w_eop) begin
              eop_out      <= 1'b1;
              pkg_cnt_incr <= 1'b1;
              pkt_len      <= '0;
              gnt          <= '0;
              state        <= IDLE;
            end else if (pkt_len == PLW'(MAX_PKT_LEN - 1)) begin
              eop_out      <= 1'b1;
              pkg_cnt_incr <= 1'b1;
              err_trunc    <= 1'b1;
              pkt_len      <= '0;
              state        <= DRAIN;
            end else begin
              pkt_len <= pkt_len + PLW'(1);
            end
          end
        end
        DRAIN: begin
          if (w_vld && w_eop) begin
            gnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abc_pkt_arb.sv
// Directed bench for abc_pkt_arb: per-channel FIFO model drives the heads,
// a monitor logs output words and grants, expected values are written by hand.
module tb_abc_pkt_arb;

  localparam int NCH = 8;
  localparam int DW  = 8;
  localparam int MPL = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    ch_vld;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_sop;
  logic [NCH-1:0]    ch_eop;
  logic [NCH-1:0]    ch_qos;
  logic [NCH-1:0]    ch_pop;
  logic [DW-1:0]     data_out;
  logic              sop_out, eop_out, qos_out, data_vld;
  logic [2:0]        id_out;
  logic              pkg_cnt_incr, err_orphan, err_trunc;
  logic [NCH-1:0]    gnt;
  logic [1:0]        state_dbg;

  abc_pkt_arb #(.NCH(NCH), .DW(DW), .MAX_HI_BURST(4), .MAX_PKT_LEN(MPL)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_vld(ch_vld), .ch_data(ch_data), .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_qos(ch_qos),
    .ch_pop(ch_pop), .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out),
    .qos_out(qos_out), .id_out(id_out), .data_vld(data_vld), .pkg_cnt_incr(pkg_cnt_incr),
    .err_orphan(err_orphan), .err_trunc(err_trunc), .gnt(gnt), .state_dbg(state_dbg)
  );

  // channel FIFO model: {qos, sop, eop, data}
  logic [10:0] fifo_mem [NCH][64];
  int          rd_ptr [NCH];
  int          wr_ptr [NCH];

  // scoreboard: {qos, id, data, sop, eop}
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  int          exp_gnt_q[$];
  int          gnt_log[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, last_eop_cyc = 0, min_gap = 1000, max_gap = 0;
  bit have_eop = 1'b0;
  int pkt_cnt = 0, trunc_cnt = 0, orphan_cnt = 0, bad_pulse = 0;
  logic [NCH-1:0] prev_gnt = '0;
  logic [NCH-1:0] last_pop = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // driver tasks
  task automatic push_word(input int ch, input logic q, input logic s, input logic e,
                           input logic [7:0] d);
    fifo_mem[ch][wr_ptr[ch]] = {q, s, e, d};
    wr_ptr[ch]++;
  endtask

  task automatic push_pkt(input int ch, input logic q, input int len, input int base);
    logic [7:0] d;
    for (int j = 0; j < len; j++) begin
      d = 8'(base + j);
      push_word(ch, q, j == 0, j == len - 1, d);
    end
  endtask

  task automatic exp_pkt(input int ch, input logic q, input int base, input int nout,
                         input bit last_eop);
    logic [2:0] c;
    logic [7:0] d;
    c = 3'(ch);
    for (int j = 0; j < nout; j++) begin
      d = 8'(base + j);
      exp_q.push_back({q, c, d, j == 0, (j == nout - 1) && last_eop});
    end
  endtask

  task automatic drive_heads();
    logic [10:0] w;
    for (int ch = 0; ch < NCH; ch++) begin
      if (rd_ptr[ch] < wr_ptr[ch]) begin
        w = fifo_mem[ch][rd_ptr[ch]];
        ch_vld[ch] = 1'b1;
        ch_qos[ch] = w[10];
        ch_sop[ch] = w[9];
        ch_eop[ch] = w[8];
        ch_data[ch*DW +: DW] = w[7:0];
      end else begin
        ch_vld[ch] = 1'b0;
        ch_qos[ch] = 1'b0;
        ch_sop[ch] = 1'b0;
        ch_eop[ch] = 1'b0;
        ch_data[ch*DW +: DW] = '0;
      end
    end
  endtask

  task automatic monitor();
    cyc++;
    if (data_vld) begin
      obs_q.push_back({qos_out, id_out, data_out, sop_out, eop_out});
      if (sop_out && have_eop) begin
        if (cyc - last_eop_cyc < min_gap) min_gap = cyc - last_eop_cyc;
        if (cyc - last_eop_cyc > max_gap) max_gap = cyc - last_eop_cyc;
      end
      if (eop_out) begin
        last_eop_cyc = cyc;
        have_eop = 1'b1;
      end
    end
    if (gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < NCH; i++) if (gnt[i]) gnt_log.push_back(i);
    end
    prev_gnt = gnt;
    if (pkg_cnt_incr) pkt_cnt++;
    if (err_trunc) trunc_cnt++;
    if (err_orphan) orphan_cnt++;
    if (pkg_cnt_incr && !(data_vld && eop_out)) bad_pulse++;
    if (err_trunc && !(data_vld && eop_out && pkg_cnt_incr)) bad_pulse++;
  endtask

  task automatic tick();
    @(negedge clk);
    last_pop = ch_pop;
    @(posedge clk);
    #1;
    for (int ch = 0; ch < NCH; ch++)
      if (last_pop[ch] && rd_ptr[ch] < wr_ptr[ch]) rd_ptr[ch]++;
    drive_heads();
    monitor();
  endtask

  function automatic bit fifos_empty();
    for (int ch = 0; ch < NCH; ch++) if (rd_ptr[ch] < wr_ptr[ch]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_logs();
    exp_q.delete(); obs_q.delete(); exp_gnt_q.delete(); gnt_log.delete();
    have_eop = 1'b0; min_gap = 1000; max_gap = 0;
    pkt_cnt = 0; trunc_cnt = 0; orphan_cnt = 0; bad_pulse = 0;
  endtask

  task automatic clear_fifos();
    for (int ch = 0; ch < NCH; ch++) begin
      rd_ptr[ch] = 0;
      wr_ptr[ch] = 0;
    end
    drive_heads();
  endtask

  task automatic do_reset(input bit check_outs);
    rst_n = 1'b0;
    clear_fifos();
    #1;
    if (check_outs) begin
      check("rst_gnt", 32'(gnt), 0);
      check("rst_data_vld", 32'(data_vld), 0);
      check("rst_data_out", 32'(data_out), 0);
      check("rst_flags", {26'd0, sop_out, eop_out, qos_out, pkg_cnt_incr, err_orphan, err_trunc}, 0);
      check("rst_id", 32'(id_out), 0);
      check("rst_pop", 32'(ch_pop), 0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic run_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((!fifos_empty() || gnt != '0 || data_vld) && n < max_cyc) begin
      tick();
      n++;
    end
    if (n >= max_cyc) check({tag, "_timeout"}, 32'(n), 32'(max_cyc - 1));
  endtask

  task automatic compare_sb(input string tag);
    check({tag, "_nwords"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_ngrants"}, 32'(gnt_log.size()), 32'(exp_gnt_q.size()));
    for (int i = 0; i < exp_gnt_q.size() && i < gnt_log.size(); i++)
      check($sformatf("%s_gnt%0d", tag, i), 32'(gnt_log[i]), 32'(exp_gnt_q[i]));
    exp_q.delete(); obs_q.delete(); exp_gnt_q.delete(); gnt_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ch_vld = '0; ch_data = '0; ch_sop = '0; ch_eop = '0; ch_qos = '0;
    do_reset(1'b1);

    // single 3-word packet on ch3, cycle by cycle
    push_pkt(3, 1'b0, 3, 8'hA0);
    drive_heads();
    tick();
    check("t1_gnt", 32'(gnt), 32'h08);
    check("t1_arb_vld", 32'(data_vld), 0);
    tick();
    check("t1_w0", {data_vld, sop_out, eop_out, id_out, data_out}, {1'b1, 1'b1, 1'b0, 3'd3, 8'hA0});
    tick();
    check("t1_w1", {data_vld, sop_out, eop_out, id_out, data_out}, {1'b1, 1'b0, 1'b0, 3'd3, 8'hA1});
    tick();
    check("t1_w2", {data_vld, sop_out, eop_out, pkg_cnt_incr, id_out, data_out},
          {1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 8'hA2});
    tick();
    check("t1_idle", {data_vld, pkg_cnt_incr, gnt}, 0);
    check("t1_hold", {id_out, data_out}, {3'd3, 8'hA2});
    exp_pkt(3, 1'b0, 8'hA0, 3, 1'b1);
    exp_gnt_q.push_back(3);
    compare_sb("t1");

    // round-robin among ch1, ch4, ch6
    do_reset(1'b0);
    push_pkt(1, 1'b0, 2, 8'h10); push_pkt(1, 1'b0, 2, 8'h12);
    push_pkt(4, 1'b0, 2, 8'h40); push_pkt(4, 1'b0, 2, 8'h42);
    push_pkt(6, 1'b0, 2, 8'h60); push_pkt(6, 1'b0, 2, 8'h62);
    drive_heads();
    run_idle("t2", 200);
    exp_pkt(1, 1'b0, 8'h10, 2, 1'b1); exp_pkt(4, 1'b0, 8'h40, 2, 1'b1); exp_pkt(6, 1'b0, 8'h60, 2, 1'b1);
    exp_pkt(1, 1'b0, 8'h12, 2, 1'b1); exp_pkt(4, 1'b0, 8'h42, 2, 1'b1); exp_pkt(6, 1'b0, 8'h62, 2, 1'b1);
    for (int r = 0; r < 2; r++) begin
      exp_gnt_q.push_back(1); exp_gnt_q.push_back(4); exp_gnt_q.push_back(6);
    end
    check("t2_min_gap", 32'(min_gap), 2);
    check("t2_max_gap", 32'(max_gap), 2);
    check("t2_pkts", 32'(pkt_cnt), 6);
    compare_sb("t2");

    // QoS with burst limit: ch0 high, ch5 low, single-word packets
    do_reset(1'b0);
    for (int k = 0; k < 8; k++) push_pkt(0, 1'b1, 1, 8'h80 + k);
    push_pkt(5, 1'b0, 1, 8'h50);
    push_pkt(5, 1'b0, 1, 8'h51);
    drive_heads();
    run_idle("t3", 200);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        exp_gnt_q.push_back(0);
        exp_pkt(0, 1'b1, 8'h80 + 4*r + k, 1, 1'b1);
      end
      exp_gnt_q.push_back(5);
      exp_pkt(5, 1'b0, 8'h50 + r, 1, 1'b1);
    end
    check("t3_pkts", 32'(pkt_cnt), 10);
    compare_sb("t3");

    // truncation at 4 words, then a normal 2-word and an exact 4-word packet
    do_reset(1'b0);
    push_pkt(2, 1'b0, 6, 8'h20);
    push_pkt(2, 1'b0, 2, 8'h30);
    push_pkt(2, 1'b0, 4, 8'h40);
    drive_heads();
    run_idle("t4", 200);
    exp_pkt(2, 1'b0, 8'h20, 4, 1'b1);
    exp_pkt(2, 1'b0, 8'h30, 2, 1'b1);
    exp_pkt(2, 1'b0, 8'h40, 4, 1'b1);
    for (int r = 0; r < 3; r++) exp_gnt_q.push_back(2);
    check("t4_trunc", 32'(trunc_cnt), 1);
    check("t4_pkts", 32'(pkt_cnt), 3);
    check("t4_bad_pulse", 32'(bad_pulse), 0);
    check("t4_drained", 32'(fifos_empty()), 1);
    compare_sb("t4");

    // orphan flush alone, then together with an arbitration
    do_reset(1'b0);
    push_word(7, 1'b0, 1'b0, 1'b0, 8'h77);
    drive_heads();
    tick();
    check("t5_pop", 32'(last_pop), 32'h80);
    check("t5_err", {err_orphan, data_vld, gnt}, {1'b1, 1'b0, 8'h00});
    tick();
    check("t5_err_clr", {err_orphan, last_pop}, 0);
    push_word(7, 1'b0, 1'b0, 1'b0, 8'h78);
    push_pkt(1, 1'b0, 1, 8'h11);
    drive_heads();
    tick();
    check("t5b_pop", 32'(last_pop), 32'h80);
    check("t5b_gnt", {err_orphan, gnt}, {1'b1, 8'h02});
    run_idle("t5", 50);
    exp_pkt(1, 1'b0, 8'h11, 1, 1'b1);
    exp_gnt_q.push_back(1);
    check("t5_orphans", 32'(orphan_cnt), 2);
    compare_sb("t5");

    // reset in the middle of a 5-word packet on ch2
    do_reset(1'b0);
    push_pkt(2, 1'b0, 5, 8'h60);
    drive_heads();
    tick(); tick(); tick();
    check("t6_w1", {data_vld, data_out}, {1'b1, 8'h61});
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {data_vld, sop_out, eop_out, pkg_cnt_incr, err_trunc, id_out, data_out}, 0);
    check("t6_rst_gnt_pop", {gnt, ch_pop}, 0);
    exp_pkt(2, 1'b0, 8'h60, 2, 1'b0);
    exp_gnt_q.push_back(2);
    compare_sb("t6a");
    clear_fifos();
    tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    push_pkt(0, 1'b0, 2, 8'h70);
    push_pkt(5, 1'b0, 2, 8'h58);
    drive_heads();
    run_idle("t6", 100);
    exp_pkt(0, 1'b0, 8'h70, 2, 1'b1);
    exp_pkt(5, 1'b0, 8'h58, 2, 1'b1);
    exp_gnt_q.push_back(0);
    exp_gnt_q.push_back(5);
    compare_sb("t6b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
